// File: rtl/univ_shift_reg.sv
// Universal shift register: hold, shift right, shift left and parallel load, with a saturating shift counter.
// Define ROTATE_EN to make the rot input turn the two shift modes into rotates.
module univ_shift_reg #(
  parameter int                 WIDTH     = 8,
  parameter logic [WIDTH-1:0]   RESET_VAL = '0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic [1:0]                    mode,
  input  logic                          sin_r,
  input  logic                          sin_l,
  input  logic                          rot,
  input  logic [WIDTH-1:0]              d,
  output logic [WIDTH-1:0]              q,
  output logic                          sout_r,
  output logic                          sout_l,
  output logic [$clog2(WIDTH+1)-1:0]    shift_cnt,
  output logic                          full
);

  localparam int            CW      = $clog2(WIDTH+1);
  localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH);

  localparam logic [1:0] MODE_HOLD  = 2'b00;
  localparam logic [1:0] MODE_RIGHT = 2'b01;
  localparam logic [1:0] MODE_LEFT  = 2'b10;
  localparam logic [1:0] MODE_LOAD  = 2'b11;

  logic [WIDTH-1:0] q_nxt;
  logic [CW-1:0]    cnt_nxt;
  logic             in_r;
  logic             in_l;

`ifdef ROTATE_EN
  // Rotation simply recirculates the opposite end bit in place of the serial input.
  assign in_r = rot ? q[0]       : sin_r;
  assign in_l = rot ? q[WIDTH-1] : sin_l;
`else
  logic unused_rot;
  assign unused_rot = rot;
  assign in_r       = sin_r;
  assign in_l       = sin_l;
`endif

  always_comb begin
    q_nxt   = q;
    cnt_nxt = shift_cnt;
    case (mode)
      MODE_HOLD: begin
        q_nxt   = q;
        cnt_nxt = shift_cnt;
      end
      MODE_RIGHT: begin
        q_nxt   = {in_r, q[WIDTH-1:1]};
        cnt_nxt = (shift_cnt == CNT_MAX) ? CNT_MAX : shift_cnt + 1'b1;
      end
      MODE_LEFT: begin
        q_nxt   = {q[WIDTH-2:0], in_l};
        cnt_nxt = (shift_cnt == CNT_MAX) ? CNT_MAX : shift_cnt + 1'b1;
      end
      MODE_LOAD: begin
        q_nxt   = d;
        cnt_nxt = '0;
      end
      default: begin
        q_nxt   = q;
        cnt_nxt = shift_cnt;
      end
    endcase
  end

  // full is registered from the next count so it rises together with shift_cnt reaching WIDTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      q         <= RESET_VAL;
      shift_cnt <= '0;
      full      <= 1'b0;
    end else if (en) begin
      q         <= q_nxt;
      shift_cnt <= cnt_nxt;
      full      <= (cnt_nxt == CNT_MAX);
    end
  end

  assign sout_r = q[0];
  assign sout_l = q[WIDTH-1];

endmodule

// File: tb/tb_univ_shift_reg.sv
// Bench for univ_shift_reg (WIDTH=8, RESET_VAL=0): directed sequences plus random traffic,
// checked against an arithmetic reference model through an expected-value queue.
module tb_univ_shift_reg;

  localparam int W  = 8;
  localparam int CW = $clog2(W+1);
  localparam int EW = W + CW + 1;

  // clock / reset block
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b0;
  logic          en = 1'b0;
  logic [1:0]    mode = 2'b00;
  logic          sin_r = 1'b0;
  logic          sin_l = 1'b0;
  logic          rot = 1'b0;
  logic [W-1:0]  d = '0;
  logic [W-1:0]  q;
  logic          sout_r;
  logic          sout_l;
  logic [CW-1:0] shift_cnt;
  logic          full;

  univ_shift_reg #(.WIDTH(W), .RESET_VAL(8'h00)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .sin_r(sin_r), .sin_l(sin_l),
    .rot(rot), .d(d), .q(q), .sout_r(sout_r), .sout_l(sout_l),
    .shift_cnt(shift_cnt), .full(full)
  );

  int total = 0;
  int bad   = 0;
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] mon_item;

  // reference model state: register value and shifts since last load/reset
  int model_val;
  int model_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  // driver: apply one cycle of stimulus, advance the model, queue the expected state
  task automatic step(input logic r, input logic e, input logic [1:0] m, input logic sr,
                      input logic sl, input logic ro, input logic [W-1:0] dd);
    int ins;
    @(negedge clk);
    rst = r; en = e; mode = m; sin_r = sr; sin_l = sl; rot = ro; d = dd;
    if (r) begin
      model_val = 0;
      model_cnt = 0;
    end else if (e) begin
      if (m == 2'd1) begin
        ins = int'(sr);
`ifdef ROTATE_EN
        if (ro) ins = model_val % 2;
`endif
        model_val = (model_val / 2) + ins * (1 << (W-1));
        model_cnt = (model_cnt < W) ? model_cnt + 1 : W;
      end else if (m == 2'd2) begin
        ins = int'(sl);
`ifdef ROTATE_EN
        if (ro) ins = (model_val >= (1 << (W-1))) ? 1 : 0;
`endif
        model_val = (model_val * 2) % (1 << W) + ins;
        model_cnt = (model_cnt < W) ? model_cnt + 1 : W;
      end else if (m == 2'd3) begin
        model_val = int'(dd);
        model_cnt = 0;
      end
    end
    exp_q.push_back({W'(model_val), CW'(model_cnt), (model_cnt == W)});
    @(posedge clk);
    #2;
  endtask

  task automatic load(input logic [W-1:0] dd);
    step(1'b0, 1'b1, 2'b11, 1'b0, 1'b0, 1'b0, dd);
  endtask

  // monitor / scoreboard: one expected state per clock once stimulus has started
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_item = exp_q.pop_front();
      check("q", 32'(q), 32'(mon_item[EW-1 -: W]));
      check("shift_cnt", 32'(shift_cnt), 32'(mon_item[CW:1]));
      check("full", 32'(full), 32'(mon_item[0]));
      check("sout_r", 32'(sout_r), 32'(mon_item[CW+1]));
      check("sout_l", 32'(sout_l), 32'(mon_item[EW-1]));
    end
  end

  initial begin
    model_val = 0;
    model_cnt = 0;

    // reset then load
    step(1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 8'h00);
    check("reset_q", 32'(q), 32'h00);
    check("reset_cnt", 32'(shift_cnt), 0);
    check("reset_full", 32'(full), 0);
    load(8'hA5);
    check("load_q", 32'(q), 32'hA5);
    check("load_cnt", 32'(shift_cnt), 0);

    // shift right three times with sin_r=1
    repeat (3) step(1'b0, 1'b1, 2'b01, 1'b1, 1'b0, 1'b0, 8'h00);
    check("shr3_q", 32'(q), 32'hF4);
    check("shr3_sout_r", 32'(sout_r), 0);
    check("shr3_cnt", 32'(shift_cnt), 3);

    // shift left to saturation and beyond
    load(8'h01);
    for (int i = 1; i <= 9; i++) begin
      step(1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 8'h00);
      if (i == 7) begin
        check("shl7_q", 32'(q), 32'h80);
        check("shl7_full", 32'(full), 0);
      end
      if (i >= 8) begin
        check("shl_sat_full", 32'(full), 1);
        check("shl_sat_cnt", 32'(shift_cnt), 8);
      end
    end
    check("shl9_q", 32'(q), 32'h00);
    load(8'h5A);
    check("full_clear_on_load", 32'(full), 0);

    // enable and reset priority
    load(8'h3C);
    step(1'b0, 1'b0, 2'b11, 1'b1, 1'b1, 1'b1, 8'hFF);
    check("en0_hold_q", 32'(q), 32'h3C);
    step(1'b1, 1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 8'hFF);
    check("rst_prio_q", 32'(q), 32'h00);
    check("rst_prio_cnt", 32'(shift_cnt), 0);

    // rotate select
    load(8'h81);
    step(1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 1'b1, 8'h00);
`ifdef ROTATE_EN
    check("rotr_q", 32'(q), 32'hC0);
    step(1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 1'b1, 8'h00);
    check("rotl_q", 32'(q), 32'h81);
    check("rot_cnt", 32'(shift_cnt), 2);
`else
    check("norot_q", 32'(q), 32'h40);
`endif

    // alternating directions each count
    load(8'h00);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, (i % 2 == 0) ? 2'b01 : 2'b10, 1'b1, 1'b1, 1'b0, 8'h00);
    check("alt_cnt", 32'(shift_cnt), 4);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 31) == 0), ($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           8'($urandom_range(0, 255)));
    end

    @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/univ_shift_reg.md
UNIV_SHIFT_REG -- requirements
Module: univ_shift_reg

Interface
REQ-001 Parameter WIDTH, default 8, register width in bits; legal range 2..32.
REQ-002 Parameter RESET_VAL, default 0, WIDTH-bit value loaded into q on reset.
REQ-003 clk  input  1  rising-edge clock; the only clock.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 en  input  1  clock enable; when 0, all state holds.
REQ-006 mode  input  2  operation select: 00 hold, 01 shift right, 10 shift left, 11 parallel load.
REQ-007 sin_r  input  1  serial input entering q[WIDTH-1] on shift right.
REQ-008 sin_l  input  1  serial input entering q[0] on shift left.
REQ-009 rot  input  1  rotate select for shift modes; present in all builds, used only under ROTATE_EN.
REQ-010 d  input  WIDTH  parallel load data.
REQ-011 q  output  WIDTH  register contents.
REQ-012 sout_r  output  1  q[0], the bit shifted out on shift right.
REQ-013 sout_l  output  1  q[WIDTH-1], the bit shifted out on shift left.
REQ-014 shift_cnt  output  $clog2(WIDTH+1)  shifts since last load or reset, saturating.
REQ-015 full  output  1  high when shift_cnt == WIDTH.

Function
REQ-016 All state shall update only on the rising edge of clk; q, shift_cnt and full shall be registered outputs, and sout_r/sout_l shall be combinational taps of q.
REQ-017 Priority shall be rst, then en, then mode.
REQ-018 With en=1 and mode=00, q and shift_cnt shall hold.
REQ-019 With en=1 and mode=01, the next q shall be {sin_r, q[WIDTH-1:1]}, a latency of one cycle.
REQ-020 With en=1 and mode=10, the next q shall be {q[WIDTH-2:0], sin_l}.
REQ-021 With en=1 and mode=11, the next q shall be d and the next shift_cnt shall be 0.
REQ-022 Each enabled shift (mode 01 or 10) shall increment shift_cnt by 1, saturating at WIDTH; shifts after saturation shall still move q.
REQ-023 full shall be asserted in the same cycle shift_cnt reaches WIDTH, and shall clear on the next load or reset.
REQ-024 Alternating left and right shifts shall each increment shift_cnt; the count shall not be direction-aware.
REQ-025 With en=0, the mode, d, sin_r, sin_l and rot inputs shall have no effect.

Reset
REQ-026 On any clock edge with rst=1: q = RESET_VAL, shift_cnt = 0, full = 0, regardless of en and mode.
REQ-027 A reset asserted mid-sequence shall discard any shift or load in progress for that cycle, and no partial update shall occur.
REQ-028 Outputs are undefined until the first clock edge with rst=1; there is no power-on initial value.

Configuration
REQ-029 The macro ROTATE_EN shall enable rotate operation.
REQ-030 With ROTATE_EN defined and rot=1: mode 01 shall give {q[0], q[WIDTH-1:1]}, mode 10 shall give {q[WIDTH-2:0], q[WIDTH-1]}, sin_r and sin_l shall be ignored, and shift_cnt shall count as for a normal shift.
REQ-031 With ROTATE_EN undefined, rot shall be ignored, behaviour shall be per REQ-019/REQ-020, and no rotate logic shall be synthesised.

Verification (WIDTH=8, RESET_VAL=0)
REQ-032 Reset then load: rst=1 for 1 cycle, then en=1, mode=11, d=8'hA5 -> after reset q=0x00, shift_cnt=0, full=0; one cycle later q=0xA5, shift_cnt=0.
REQ-033 Shift right: from q=0xA5, 3 cycles of mode=01 with sin_r=1 -> q=0xF4, sout_r=0, shift_cnt=3.
REQ-034 Shift left to saturation: from a load of 0x01, 9 cycles of mode=10 with sin_l=0 -> q=0x80 after 7 shifts, q=0x00 after 9, full=1 from shift 8, shift_cnt=8 at shifts 8 and 9.
REQ-035 Enable and reset priority: from q=0x3C, en=0 with mode=11 and d=0xFF -> q stays 0x3C; then rst=1 with en=1 and mode=11 in the same cycle -> q=0x00, shift_cnt=0.
REQ-036 Rotate (ROTATE_EN defined): from q=0x81, rot=1, mode=01, sin_r=0, one cycle -> q=0xC0; then mode=10 -> q=0x81, shift_cnt=2.
REQ-037 Rotate disabled (ROTATE_EN undefined): from q=0x81, rot=1, mode=01, sin_r=0 -> q=0x40.
